axi_lite_bridge_q: RTL and testbench

Parametrised client-to-AXI4-Lite bridge with a request queue. Sits between the design's command/processing logic and the DRAM AXI4-Lite slave. Accepts up to DEPTH queued read/write requests on a simple valid/ready client port and serialises them, in order, onto AXI4-Lite. Issues AW and W concurrently and returns one response pulse per request.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/bridge_req_fifo.sv | 48 ++++
 rtl/axi_lite_bridge_q.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_lite_bridge_q.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types for the client-to-AXI4-Lite bridge: FSM states, request record
// and the AXI response code treated as success.
package bridge_pkg;

    parameter int ADDR_W = 17;
    parameter int DATA_W = 64;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_DONE
    } bridge_st_e;

    typedef struct packed {
        logic              r_wb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bridge_req_t;

endpackage

// File: rtl/bridge_req_fifo.sv
// Request queue for the AXI4-Lite bridge: first-word-fall-through FIFO with
// wrap-bit pointers, so full and empty need no separate occupancy counter.
module bridge_req_fifo #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;

    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign rdata = mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axi_lite_bridge_q.sv
// Queued client-to-AXI4-Lite bridge: one transaction in flight, strict order.
// Define BRIDGE_RESP_CHK_EN to add the C_err port driven from RRESP/BRESP.
module axi_lite_bridge_q #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              C_in_valid,
    output logic              C_in_ready,
    input  logic              C_r_wb,
    input  logic [ADDR_W-1:0] C_addr,
    input  logic [DATA_W-1:0] C_data_w,
    output logic              C_out_valid,
    output logic [DATA_W-1:0] C_data_r,
`ifdef BRIDGE_RESP_CHK_EN
    output logic              C_err,
`endif
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic              R_VALID,
    output logic              R_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [1:0]        B_RESP
);
    import bridge_pkg::*;

    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    logic [REQ_W-1:0]  head;
    logic              head_r_wb;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              ready_reg;

    bridge_st_e        state_reg, state_next;
    logic              ar_valid_reg, ar_valid_next;
    logic [ADDR_W-1:0] ar_addr_reg, ar_addr_next;
    logic              r_ready_reg, r_ready_next;
    logic              aw_valid_reg, aw_valid_next;
    logic [ADDR_W-1:0] aw_addr_reg, aw_addr_next;
    logic              w_valid_reg, w_valid_next;
    logic [DATA_W-1:0] w_data_reg, w_data_next;
    logic              aw_done_reg, aw_done_next;
    logic              w_done_reg, w_done_next;
    logic              b_ready_reg, b_ready_next;
    logic [DATA_W-1:0] data_r_reg, data_r_next;
    logic              out_valid_reg, out_valid_next;

    assign {head_r_wb, head_addr, head_data} = head;

    // ready_reg keeps C_in_ready low through reset and for the first edge after it.
    assign C_in_ready = ready_reg && !fifo_full;
    assign fifo_push  = C_in_valid && C_in_ready;

    bridge_req_fifo #(
        .WIDTH(REQ_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({C_r_wb, C_addr, C_data_w}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg     <= 1'b0;
            state_reg     <= ST_IDLE;
            ar_valid_reg  <= 1'b0;
            ar_addr_reg   <= '0;
            r_ready_reg   <= 1'b0;
            aw_valid_reg  <= 1'b0;
            aw_addr_reg   <= '0;
            w_valid_reg   <= 1'b0;
            w_data_reg    <= '0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            b_ready_reg   <= 1'b0;
            data_r_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            ready_reg     <= 1'b1;
            state_reg     <= state_next;
            ar_valid_reg  <= ar_valid_next;
            ar_addr_reg   <= ar_addr_next;
            r_ready_reg   <= r_ready_next;
            aw_valid_reg  <= aw_valid_next;
            aw_addr_reg   <= aw_addr_next;
            w_valid_reg   <= w_valid_next;
            w_data_reg    <= w_data_next;
            aw_done_reg   <= aw_done_next;
            w_done_reg    <= w_done_next;
            b_ready_reg   <= b_ready_next;
            data_r_reg    <= data_r_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ar_valid_next  = ar_valid_reg;
        ar_addr_next   = ar_addr_reg;
        r_ready_next   = r_ready_reg;
        aw_valid_next  = aw_valid_reg;
        aw_addr_next   = aw_addr_reg;
        w_valid_next   = w_valid_reg;
        w_data_next    = w_data_reg;
        aw_done_next   = aw_done_reg;
        w_done_next    = w_done_reg;
        b_ready_next   = b_ready_reg;
        data_r_next    = data_r_reg;
        out_valid_next = 1'b0;
        fifo_pop       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_r_wb) begin
                        ar_valid_next = 1'b1;
                        ar_addr_next  = head_addr;
                        state_next    = ST_RD_ADDR;
                    end else begin
                        aw_valid_next = 1'b1;
                        aw_addr_next  = head_addr;
                        w_valid_next  = 1'b1;
                        w_data_next   = head_data;
                        aw_done_next  = 1'b0;
                        w_done_next   = 1'b0;
                        state_next    = ST_WR_REQ;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (AR_READY) begin
                    ar_valid_next = 1'b0;
                    r_ready_next  = 1'b1;
                    state_next    = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (R_VALID) begin
                    data_r_next  = R_DATA;
                    r_ready_next = 1'b0;
                    state_next   = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently, possibly in the same cycle.
                if (aw_valid_reg && AW_READY) begin
                    aw_valid_next = 1'b0;
                    aw_done_next  = 1'b1;
                end
                if (w_valid_reg && W_READY) begin
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    b_ready_next = 1'b1;
                    state_next   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (B_VALID) begin
                    b_ready_next = 1'b0;
                    data_r_next  = '0;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid_next = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign AR_VALID    = ar_valid_reg;
    assign AR_ADDR     = ar_addr_reg;
    assign R_READY     = r_ready_reg;
    assign AW_VALID    = aw_valid_reg;
    assign AW_ADDR     = aw_addr_reg;
    assign W_VALID     = w_valid_reg;
    assign W_DATA      = w_data_reg;
    assign B_READY     = b_ready_reg;
    assign C_data_r    = data_r_reg;
    assign C_out_valid = out_valid_reg;

`ifdef BRIDGE_RESP_CHK_EN
    logic err_reg;
    logic err_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg     <= 1'b0;
            err_out_reg <= 1'b0;
        end else begin
            if (state_reg == ST_RD_DATA && R_VALID) begin
                err_reg <= (R_RESP != RESP_OKAY);
            end else if (state_reg == ST_WR_RESP && B_VALID) begin
                err_reg <= (B_RESP != RESP_OKAY);
            end
            err_out_reg <= (state_reg == ST_DONE) && err_reg;
        end
    end

    assign C_err = err_out_reg;
`else
    logic unused_resp;
    assign unused_resp = ^{R_RESP, B_RESP};
`endif

endmodule

// File: tb/tb_axi_lite_bridge_q.sv
// Bench for axi_lite_bridge_q: negedge-driven AXI4-Lite slave model plus a
// completion scoreboard; build with BRIDGE_RESP_CHK_EN to cover C_err.
module tb_axi_lite_bridge_q;
    import bridge_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        C_in_valid = 1'b0, C_in_ready, C_r_wb = 1'b0;
    logic [16:0] C_addr = '0;
    logic [63:0] C_data_w = '0;
    logic        C_out_valid;
    logic [63:0] C_data_r;
`ifdef BRIDGE_RESP_CHK_EN
    logic        C_err;
`endif
    logic        AR_VALID, AR_READY = 1'b0;
    logic [16:0] AR_ADDR;
    logic        R_VALID = 1'b0, R_READY;
    logic [63:0] R_DATA = '0;
    logic [1:0]  R_RESP = '0;
    logic        AW_VALID, AW_READY = 1'b0;
    logic [16:0] AW_ADDR;
    logic        W_VALID, W_READY = 1'b0;
    logic [63:0] W_DATA;
    logic        B_VALID = 1'b0, B_READY;
    logic [1:0]  B_RESP = '0;

    axi_lite_bridge_q #(.ADDR_W(17), .DATA_W(64), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .C_in_valid(C_in_valid), .C_in_ready(C_in_ready), .C_r_wb(C_r_wb),
        .C_addr(C_addr), .C_data_w(C_data_w),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r),
`ifdef BRIDGE_RESP_CHK_EN
        .C_err(C_err),
`endif
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    // Slave configuration and observation state
    bit          s_stall = 0, s_r_hold = 0;
    int          s_aw_delay = 0, s_w_delay = 0, aw_wait = 0, w_wait = 0;
    logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
    bit          r_pend = 0, aw_hs_pend = 0, w_hs_pend = 0;
    bit          aw_dup = 0, w_dup = 0, aw_addr_changed = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [16:0] last_ar_addr = '0, last_aw_addr = '0;
    logic [63:0] last_w_data = '0;
    logic        p_arv = 0, p_rready = 0, p_awv = 0, p_wv = 0, p_bready = 0;
    logic [16:0] p_araddr = '0, p_awaddr = '0;
    logic [63:0] p_wdata = '0;

    function automatic logic [63:0] rd_model(input logic [16:0] a);
        return 64'h0123_4567_89AB_CDEF ^ {47'd0, a ^ 17'h00010};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave: handshakes resolved at a negedge use the values that were stable
    // across the preceding posedge, captured at the previous negedge.
    task automatic slave_step();
        if (!rst_n) begin
            AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
            r_pend = 0; aw_hs_pend = 0; w_hs_pend = 0; aw_wait = 0; w_wait = 0;
            p_arv = 0; p_rready = 0; p_awv = 0; p_wv = 0; p_bready = 0;
            return;
        end
        if (R_VALID && p_rready) begin R_VALID = 0; r_cnt++; end
        if (p_arv && AR_READY) begin ar_cnt++; last_ar_addr = p_araddr; r_pend = 1; end
        if (r_pend && !s_r_hold && !R_VALID) begin
            R_VALID = 1; R_DATA = rd_model(last_ar_addr); R_RESP = cfg_rresp; r_pend = 0;
        end
        if (p_awv && AW_READY) begin
            aw_cnt++; aw_hs_pend = 1; last_aw_addr = p_awaddr; aw_hs_cyc = cyc;
        end
        if (p_wv && W_READY) begin
            w_cnt++; w_hs_pend = 1; last_w_data = p_wdata; w_hs_cyc = cyc;
        end
        if (B_VALID && p_bready) begin B_VALID = 0; b_cnt++; end
        if (aw_hs_pend && W_VALID && w_hs_pend) w_dup = 1;
        if (AW_VALID && aw_hs_pend) aw_dup = 1;
        if (W_VALID && w_hs_pend) w_dup = 1;
        if (aw_hs_pend && w_hs_pend) begin
            B_VALID = 1; B_RESP = cfg_bresp; aw_hs_pend = 0; w_hs_pend = 0;
        end
        if (p_awv && !AW_READY && AW_VALID && AW_ADDR !== p_awaddr) aw_addr_changed = 1;
        AR_READY = AR_VALID && !s_stall;
        if (AW_VALID && !s_stall) begin
            if (aw_wait >= s_aw_delay) begin AW_READY = 1; aw_wait = 0; end
            else begin AW_READY = 0; aw_wait++; end
        end else AW_READY = 0;
        if (W_VALID && !s_stall) begin
            if (w_wait >= s_w_delay) begin W_READY = 1; w_wait = 0; end
            else begin W_READY = 0; w_wait++; end
        end else W_READY = 0;
        p_arv = AR_VALID; p_araddr = AR_ADDR; p_rready = R_READY;
        p_awv = AW_VALID; p_awaddr = AW_ADDR; p_wv = W_VALID; p_wdata = W_DATA;
        p_bready = B_READY;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    // Completion monitor / scoreboard
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && C_out_valid) begin
            n_done++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_completion: got C_data_r=%h, no completion expected", C_data_r);
            end else begin
                e = exp_q.pop_front();
                if (C_data_r !== e.data) begin
                    n_fail++;
                    $display("FAIL completion_data: got %h, expected %h", C_data_r, e.data);
                end
`ifdef BRIDGE_RESP_CHK_EN
                n_checks++;
                if (C_err !== e.err) begin
                    n_fail++;
                    $display("FAIL completion_err: got %b, expected %b", C_err, e.err);
                end
`endif
            end
            $display("completion #%0d at cycle %0d: data=%h", n_done, cyc, C_data_r);
        end
    end

    task automatic push_req(input bridge_req_t rq);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        C_in_valid = 1; C_r_wb = rq.r_wb; C_addr = rq.addr; C_data_w = rq.data;
        while (C_in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        n_checks++;
        if (C_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_timeout: C_in_ready=%b, expected 1", C_in_ready);
            C_in_valid = 0;
        end else begin
            e.data = rq.r_wb ? rd_model(rq.addr) : 64'd0;
            e.err  = rq.r_wb ? (cfg_rresp != 2'b00) : (cfg_bresp != 2'b00);
            exp_q.push_back(e);
            $display("push r_wb=%b addr=%h data=%h", rq.r_wb, rq.addr, rq.data);
            @(posedge clk);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d completions outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid, C_in_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid, C_in_ready});
        end
        n_checks++;
        if (C_data_r !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data_r: got %h, expected 0", C_data_r);
        end
`ifdef BRIDGE_RESP_CHK_EN
        n_checks++;
        if (C_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", C_err); end
`endif
        rst_n = 1;
        @(posedge clk);
        #1;
        n_checks++;
        if (C_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, expected 1", C_in_ready);
        end
        $display("reset done at cycle %0d", cyc);
    endtask

    task automatic test_single_read();
        bridge_req_t rq;
        int lat;
        rq.r_wb = 1'b1; rq.addr = 17'h00010; rq.data = 64'h5555_AAAA_5555_AAAA;
        push_req(rq);
        @(negedge clk);
        C_in_valid = 0;
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                n_checks++;
                if (AR_VALID !== 1'b1 || AR_ADDR !== 17'h00010) begin
                    n_fail++;
                    $display("FAIL read_ar_issue: AR_VALID=%b AR_ADDR=%h, expected 1/00010", AR_VALID, AR_ADDR);
                end
            end
            if (C_out_valid) lat = k;
        end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL read_latency: got %0d, expected 4", lat); end
        n_checks++;
        if (C_data_r !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL read_data: got %h, expected 0123456789abcdef", C_data_r);
        end
        wait_drain(50);
    endtask

    task automatic test_single_write();
        bridge_req_t rq;
        int aw0, w0, b0;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        s_aw_delay = 3; s_w_delay = 0; aw_addr_changed = 0; aw_dup = 0; w_dup = 0;
        rq.r_wb = 1'b0; rq.addr = 17'h1FFF8; rq.data = 64'hDEAD_BEEF_CAFE_F00D;
        push_req(rq);
        @(negedge clk);
        C_in_valid = 0;
        wait_drain(100);
        n_checks++;
        if (aw_hs_cyc - w_hs_cyc != 3) begin
            n_fail++;
            $display("FAIL write_aw_after_w: got %0d cycles, expected 3", aw_hs_cyc - w_hs_cyc);
        end
        n_checks++;
        if (aw_addr_changed || last_aw_addr !== 17'h1FFF8 || last_w_data !== 64'hDEAD_BEEF_CAFE_F00D) begin
            n_fail++;
            $display("FAIL write_payload: changed=%0d addr=%h data=%h, expected 0/1fff8/deadbeefcafef00d",
                     aw_addr_changed, last_aw_addr, last_w_data);
        end
        n_checks++;
        if ({aw_cnt - aw0, w_cnt - w0, b_cnt - b0} !== {32'd1, 32'd1, 32'd1} || aw_dup || w_dup) begin
            n_fail++;
            $display("FAIL write_handshakes: aw=%0d w=%0d b=%0d dup=%0d%0d, expected 1 1 1 00",
                     aw_cnt - aw0, w_cnt - w0, b_cnt - b0, aw_dup, w_dup);
        end
        s_aw_delay = 0;
    endtask

    task automatic test_aw_w_same_cycle();
        bridge_req_t rq;
        int lat;
        aw_dup = 0; w_dup = 0;
        rq.r_wb = 1'b0; rq.addr = 17'h00400; rq.data = 64'h1122_3344_5566_7788;
        push_req(rq);
        @(negedge clk);
        C_in_valid = 0;
        lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                n_checks++;
                if ({B_READY, AW_VALID, W_VALID} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL same_cycle_wr_resp: B_READY/AW_VALID/W_VALID=%b, expected 100",
                             {B_READY, AW_VALID, W_VALID});
                end
            end
            if (C_out_valid) lat = k;
        end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL write_latency: got %0d, expected 4", lat); end
        wait_drain(50);
        n_checks++;
        if (aw_dup || w_dup) begin
            n_fail++;
            $display("FAIL same_cycle_dup_valid: aw_dup=%0d w_dup=%0d, expected 0 0", aw_dup, w_dup);
        end
    endtask

    task automatic test_back_to_back();
        bridge_req_t reqs[6];
        int acc;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            reqs[i].r_wb = (i % 2 == 0);
            reqs[i].addr = 17'h00800 + 17'(i * 8);
            reqs[i].data = {32'hB2B0_0000 + 32'(i), 32'h0F0F_0F0F};
        end
        s_stall = 1;
        acc = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (C_in_ready !== (acc < 5)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b, expected %b", i, C_in_ready, (acc < 5));
            end
            C_in_valid = 1; C_r_wb = reqs[i].r_wb; C_addr = reqs[i].addr; C_data_w = reqs[i].data;
            if (C_in_ready) begin
                acc++;
                e.data = reqs[i].r_wb ? rd_model(reqs[i].addr) : 64'd0;
                e.err  = 1'b0;
                exp_q.push_back(e);
                $display("push r_wb=%b addr=%h data=%h", reqs[i].r_wb, reqs[i].addr, reqs[i].data);
            end
            @(negedge clk);
        end
        C_in_valid = 0;
        n_checks++;
        if (C_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_hold: got %b, expected 0", C_in_ready); end
        s_stall = 0;
        wait_drain(200);
        n_checks++;
        if (C_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after: got %b, expected 1", C_in_ready); end
    endtask

`ifdef BRIDGE_RESP_CHK_EN
    task automatic test_resp_err();
        bridge_req_t rq;
        cfg_bresp = 2'b10;
        rq.r_wb = 1'b0; rq.addr = 17'h00C00; rq.data = 64'hE77E_E77E_0000_0001;
        push_req(rq);
        @(negedge clk);
        C_in_valid = 0;
        wait_drain(50);
        cfg_bresp = 2'b00;
        rq.r_wb = 1'b1; rq.addr = 17'h00C08;
        push_req(rq);
        @(negedge clk);
        C_in_valid = 0;
        wait_drain(50);
    endtask
`endif

    task automatic test_reset_mid_read();
        bridge_req_t rq;
        int n, done0;
        bit seen;
        s_r_hold = 1;
        for (int i = 0; i < 3; i++) begin
            rq.r_wb = 1'b1; rq.addr = 17'h00100 + 17'(i * 8); rq.data = '0;
            push_req(rq);
        end
        @(negedge clk);
        C_in_valid = 0;
        n = 0;
        while (R_READY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (R_READY !== 1'b1) begin n_fail++; $display("FAIL mid_read_reach: R_READY=%b, expected 1", R_READY); end
        done0 = n_done;
        rst_n = 0;
        #1;
        n_checks++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid, C_in_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b, expected 0000000",
                     {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, C_out_valid, C_in_ready});
        end
        n_checks++;
        if (C_data_r !== 64'd0 || AR_ADDR !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_reset_regs: C_data_r=%h AR_ADDR=%h, expected 0 0", C_data_r, AR_ADDR);
        end
        exp_q.delete();
        s_r_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        n_checks++;
        if (C_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b, expected 1", C_in_ready); end
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (AR_VALID || AW_VALID) seen = 1;
        end
        n_checks++;
        if (seen || n_done != done0) begin
            n_fail++;
            $display("FAIL mid_reset_queue_empty: issue_seen=%0d completions=%0d, expected 0 0", seen, n_done - done0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_aw_w_same_cycle();
        test_back_to_back();
`ifdef BRIDGE_RESP_CHK_EN
        test_resp_err();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
